cache_arbiter: RTL

Arbitrates the physical-memory ports of the instruction cache and data cache onto one shared line-wide memory port (toward the cacheline adapter / main memory). Exactly one cache line transaction is outstanding at a time. Request address, write data and operation are registered at grant, and returned read data is registered before response.

---
 rtl/cache_arbiter_pkg.sv | 16 +
 rtl/cache_arbiter_arb_select.sv | 34 +++
 rtl/cache_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the I/D cache memory-port arbiter.
package cache_arbiter_pkg;
  localparam int S_LINE_DEF = 256;
  localparam int S_ADDR_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;
endpackage

// File: rtl/cache_arbiter_arb_select.sv
// Combinational winner pick between the I-cache and D-cache requests.
// ARB_RR_EN selects round-robin; otherwise D-cache has fixed priority.
module arb_select
  import cache_arbiter_pkg::*;
(
  input  logic       i_pend,
  input  logic       d_pend,
`ifdef ARB_RR_EN
  input  requester_t last,
`endif
  output requester_t winner
);

  // Winner selection from the pending bits (and last grant in round-robin mode)
  always_comb begin
    winner = REQ_I;
`ifdef ARB_RR_EN
    if (i_pend && d_pend) begin
      winner = (last == REQ_I) ? REQ_D : REQ_I;
    end else if (d_pend) begin
      winner = REQ_D;
    end else begin
      winner = REQ_I;
    end
`else
    if (d_pend) begin
      winner = REQ_D;
    end else begin
      winner = REQ_I;
    end
`endif
  end

endmodule

// File: rtl/cache_arbiter.sv
// Single-outstanding arbiter of I-cache and D-cache line ports onto one memory port.
// Define ARB_RR_EN for round-robin arbitration; default is D-over-I fixed priority.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int s_line = S_LINE_DEF,
  parameter int s_addr = S_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_addr-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [s_line-1:0] i_pmem_wdata,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic [s_addr-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp
);

  state_t              state_r, state_next_s;
  requester_t          winner_r, grant_s;
  logic                i_pend_s, d_pend_s;
  logic [s_addr-1:0]   sel_addr_s;
  logic [s_line-1:0]   sel_wdata_s;
  logic                sel_read_s, sel_write_s;
  logic [s_addr-1:0]   mem_address_r;
  logic [s_line-1:0]   mem_wdata_r, line_r;
  logic                mem_read_r, mem_write_r, i_resp_r, d_resp_r;

  assign i_pend_s = i_pmem_read | i_pmem_write;
  assign d_pend_s = d_pmem_read | d_pmem_write;

`ifdef ARB_RR_EN
  requester_t last_r;

  arb_select u_arb_select (
    .i_pend (i_pend_s),
    .d_pend (d_pend_s),
    .last   (last_r),
    .winner (grant_s)
  );

  // Last-winner pointer, moved only when a grant is made
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= REQ_D;
    end else if (state_r == IDLE && (i_pend_s || d_pend_s)) begin
      last_r <= grant_s;
    end else begin
      last_r <= last_r;
    end
  end
`else
  arb_select u_arb_select (
    .i_pend (i_pend_s),
    .d_pend (d_pend_s),
    .winner (grant_s)
  );
`endif

  // Request fields of the selected requester
  always_comb begin
    sel_addr_s  = i_pmem_address;
    sel_wdata_s = i_pmem_wdata;
    sel_read_s  = i_pmem_read;
    sel_write_s = i_pmem_write;
    case (grant_s)
      REQ_D: begin
        sel_addr_s  = d_pmem_address;
        sel_wdata_s = d_pmem_wdata;
        sel_read_s  = d_pmem_read;
        sel_write_s = d_pmem_write;
      end
      default: begin
        sel_addr_s  = i_pmem_address;
        sel_wdata_s = i_pmem_wdata;
        sel_read_s  = i_pmem_read;
        sel_write_s = i_pmem_write;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state; mem_resp only matters while BUSY
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (i_pend_s || d_pend_s) state_next_s = BUSY; else state_next_s = IDLE;
      BUSY:    if (mem_resp) state_next_s = RESP; else state_next_s = BUSY;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Latched request, memory strobes, read line and the one-cycle responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_r      <= REQ_I;
      mem_address_r <= {s_addr{1'b0}};
      mem_wdata_r   <= {s_line{1'b0}};
      line_r        <= {s_line{1'b0}};
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      i_resp_r      <= 1'b0;
      d_resp_r      <= 1'b0;
    end else begin
      i_resp_r <= 1'b0;
      d_resp_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_pend_s || d_pend_s) begin
            winner_r      <= grant_s;
            mem_address_r <= sel_addr_s;
            mem_wdata_r   <= sel_wdata_s;
            // write wins when a requester raises both
            mem_write_r   <= sel_write_s;
            mem_read_r    <= sel_read_s & ~sel_write_s;
          end else begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            if (mem_read_r) begin
              line_r <= mem_rdata;
            end else begin
              line_r <= line_r;
            end
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            i_resp_r    <= (winner_r == REQ_I);
            d_resp_r    <= (winner_r == REQ_D);
          end else begin
            mem_read_r  <= mem_read_r;
            mem_write_r <= mem_write_r;
          end
        end
        default: begin
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address  = mem_address_r;
  assign mem_wdata    = mem_wdata_r;
  assign mem_read     = mem_read_r;
  assign mem_write    = mem_write_r;
  assign i_pmem_rdata = line_r;
  assign d_pmem_rdata = line_r;
  assign i_pmem_resp  = i_resp_r;
  assign d_pmem_resp  = d_resp_r;

endmodule
